// File: rtl/serial_sub_pkg.sv
// Shared types and sizing for the bit-serial subtractor.
package serial_sub_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Bit counter width for a given operand width (counts 0..width).
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   assign o_d    = i_a ^ i_b ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor cell.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for START; DIFF/BOUT hold the last result
//   RUN   | one bit per clock through the cell, WIDTH cycles
//   FIN   | DONE cycle; DIFF/BOUT complete, back to IDLE next edge
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] DIFF,
   output logic             BOUT
);

   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_br;
   logic             r_busy;
   logic             r_done;
   logic             w_d;
   logic             w_br_nxt;
   logic             w_last;

   full_subtractor_cell u_cell (
      .i_a    (r_a_sh[0]),
      .i_b    (r_b_sh[0]),
      .i_bin  (r_br),
      .o_d    (w_d),
      .o_bout (w_br_nxt)
   );

   assign w_last = (r_cnt == LAST_BIT);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; START is only looked at in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (START) w_state_nxt = RUN;
         RUN:     if (w_last) w_state_nxt = FIN;
         FIN:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath and registered status; BUSY/DONE are decoded from the next
   // state so they line up with the state they describe.
   // The result register doubles as DIFF: after WIDTH shifts it holds the
   // full difference and stays put until the next accepted START.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh <= '0;
         r_b_sh <= '0;
         r_res  <= '0;
         r_cnt  <= '0;
         r_br   <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != IDLE);
         r_done <= (w_state_nxt == FIN);
         case (r_state)
            IDLE: begin
               if (START) begin
                  r_a_sh <= A;
                  r_b_sh <= B;
                  r_br   <= 1'b0;
                  r_cnt  <= '0;
               end
            end
            RUN: begin
               r_a_sh <= r_a_sh >> 1;
               r_b_sh <= r_b_sh >> 1;
               r_res  <= {w_d, r_res[WIDTH-1:1]};
               r_br   <= w_br_nxt;
               r_cnt  <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign BUSY = r_busy;
   assign DONE = r_done;
   assign DIFF = r_res;
   assign BOUT = r_br;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed table, hand-written corner
// sequences, exhaustive back-to-back sweep and randomized traffic, all
// checked cycle by cycle against a timing/arithmetic reference model.
module tb_serial_subtractor;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         rst;
   logic         START;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         BUSY;
   logic         DONE;
   logic [W-1:0] DIFF;
   logic         BOUT;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .START (START),
      .A     (A),
      .B     (B),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .DIFF  (DIFF),
      .BOUT  (BOUT)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] diff;
      logic         bout;
   } vec_t;

   typedef struct {
      int a;
      int b;
   } op_t;

   vec_t tab[6];
   op_t  q[$];

   int checks     = 0;
   int errors     = 0;
   int cyc        = 0;
   int acc_cyc    = -100;
   int model_diff = 0;
   int model_bout = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit ready();
      return (cyc >= acc_cyc + W + 2);
   endfunction

   // Reference model: an accepted op makes BUSY high for W+1 cycles, DONE
   // in the last of them, and the result is plain modular arithmetic.
   task automatic step();
      bit  eb;
      bit  ed;
      op_t e;
      @(negedge clk);
      cyc++;
      eb = (cyc > acc_cyc) && (cyc <= acc_cyc + W + 1);
      ed = (cyc == acc_cyc + W + 1);
      chk("busy", {31'b0, BUSY}, {31'b0, eb});
      chk("done", {31'b0, DONE}, {31'b0, ed});
      if (ed && q.size() > 0) begin
         e          = q.pop_front();
         model_diff = (e.a - e.b + MOD) % MOD;
         model_bout = (e.a < e.b) ? 1 : 0;
         chk("diff_plus_b", {28'b0, DIFF + 4'(e.b)}, e.a);
      end
      if (!eb || ed) begin
         chk("diff", {28'b0, DIFF}, model_diff);
         chk("bout", {31'b0, BOUT}, model_bout);
      end
   endtask

   task automatic issue(input int a, input int b);
      A     = W'(a);
      B     = W'(b);
      START = 1'b1;
      if (!rst && ready()) begin
         acc_cyc = cyc;
         q.push_back('{a: a, b: b});
      end
      step();
      START = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready() && n < 50) begin
         step();
         n++;
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      acc_cyc    = -100;
      model_diff = 0;
      model_bout = 0;
      q.delete();
      step();
      rst = 1'b0;
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int n = 0;
      wait_ready();
      issue(int'(v.a), int'(v.b));
      while (DONE !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk({name, "_done_seen"}, {31'b0, DONE}, 32'd1);
      chk({name, "_latency"}, cyc - acc_cyc, W + 1);
      chk({name, "_diff"}, {28'b0, DIFF}, {28'b0, v.diff});
      chk({name, "_bout"}, {31'b0, BOUT}, {31'b0, v.bout});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      tab[0] = '{a: 4'd9,  b: 4'd3,  diff: 4'd6,  bout: 1'b0};
      tab[1] = '{a: 4'd3,  b: 4'd9,  diff: 4'd10, bout: 1'b1};
      tab[2] = '{a: 4'd0,  b: 4'd1,  diff: 4'd15, bout: 1'b1};
      tab[3] = '{a: 4'd15, b: 4'd15, diff: 4'd0,  bout: 1'b0};
      tab[4] = '{a: 4'd0,  b: 4'd0,  diff: 4'd0,  bout: 1'b0};
      tab[5] = '{a: 4'd15, b: 4'd0,  diff: 4'd15, bout: 1'b0};

      rst   = 1'b1;
      START = 1'b0;
      A     = '0;
      B     = '0;
      repeat (3) step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 6; i++) begin
         run_vec($sformatf("vec%0d", i), tab[i]);
      end

      // START pulses during RUN and FIN must be ignored.
      wait_ready();
      issue(12, 5);
      issue(1, 2);
      step();
      step();
      step();
      issue(1, 2);
      repeat (4) step();
      chk("busy_reject_diff", {28'b0, DIFF}, 32'd7);
      chk("busy_reject_bout", {31'b0, BOUT}, 32'd0);
      chk("busy_reject_queue", q.size(), 0);

      // Reset in the third RUN cycle discards the operation.
      wait_ready();
      issue(8, 1);
      step();
      step();
      do_reset();
      chk("rst_mid_busy", {31'b0, BUSY}, 32'd0);
      chk("rst_mid_diff", {28'b0, DIFF}, 32'd0);
      repeat (8) step();
      v = '{a: 4'd5, b: 4'd2, diff: 4'd3, bout: 1'b0};
      run_vec("after_rst", v);

      // Exhaustive sweep at maximum issue rate.
      for (int a = 0; a < MOD; a++) begin
         for (int b = 0; b < MOD; b++) begin
            wait_ready();
            issue(a, b);
         end
      end
      wait_ready();

      // Randomized traffic with stray STARTs and occasional resets.
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 19))
            0:             do_reset();
            1, 2, 3, 4, 5: issue(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)));
            default:       step();
         endcase
      end
      repeat (10) step();
      chk("final_queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
